matrix_result_writer: RTL and testbench

- Writeback end of the matrix processor datapath.
- Accepts one finished dot-product word per write strobe from the FMA/controller side and buffers it in a small FIFO.
- Drains the FIFO to memory over a valid/ready write-request interface, at sequential addresses from a latched base.
- Counts results per job and signals completion once every result of every work item has been accepted by memory.

---
 rtl/matrix_proc_pkg.sv | 14 +
 rtl/matrix_result_writer_if.sv | 29 ++
 rtl/matrix_result_writer_fifo.sv | 48 ++++
 rtl/matrix_result_writer.sv | 125 ++++++++++++
 tb/tb_matrix_result_writer.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_proc_pkg.sv
// Shared types and constants for the matrix processor datapath.
package matrix_proc_pkg;

    // Writeback sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } writer_state_t;

    // Each work item produces this many dot-product result words.
    localparam int RESULTS_PER_WI = 4;

endpackage

// File: rtl/matrix_result_writer_if.sv
// Memory write-request bus between the result writer and the memory system.
//
// Handshake: a request transfers on a rising clk edge where mem_req_valid and
// mem_req_ready are both high. Once mem_req_valid rises, mem_req_addr and
// mem_req_data hold stable until that edge. mem_req_valid never depends
// combinationally on mem_req_ready.
interface matrix_result_writer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        output mem_req_data,
        input  mem_req_ready
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        input  mem_req_data,
        output mem_req_ready
    );
endinterface

// File: rtl/matrix_result_writer_fifo.sv
// Small synchronous result buffer. Head is read straight from the array so a
// word written into an empty buffer is visible the cycle after the push.
// A push while full is taken only when a pop frees the slot in the same cycle.
module result_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Extra pointer bit tells full from empty when the indices coincide.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Advance read/write pointers; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage array; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/matrix_result_writer.sv
// Writeback end of the matrix datapath: buffers result words, writes them to
// sequential addresses from a latched base, and pulses done once the whole job
// (wi_count * RESULTS_PER_WI words) has been accepted by memory.
module matrix_result_writer
    import matrix_proc_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int WI_W       = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [WI_W-1:0]        wi_count,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    matrix_result_writer_if.master mem,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output writer_state_t          dbg_state
);
    // Job totals are wi_count * 4, which needs two extra bits.
    localparam int TOT_W = WI_W + 2;
    localparam logic [TOT_W-1:0] CNT_ONE = {{(TOT_W-1){1'b0}}, 1'b1};

    writer_state_t     state;
    writer_state_t     next_state;
    logic [ADDR_W-1:0] base_q;
    logic [TOT_W-1:0]  total_q;
    logic [TOT_W-1:0]  rx_cnt;
    logic [TOT_W-1:0]  tx_cnt;
    logic              overflow_q;

    logic              active;
    logic              accept_start;
    logic              push;
    logic              pop;
    logic              drop;
    logic              req_valid;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;

    assign active       = (state == ACTIVE);
    assign accept_start = (state == IDLE) && start;
    assign req_valid    = active && !fifo_empty;
    assign pop          = req_valid && mem.mem_req_ready;
    // A word is taken only while the job still expects results and there is
    // room, counting a slot freed by a same-cycle pop.
    assign push         = active && in_valid && (rx_cnt != total_q) && (!fifo_full || pop);
    assign drop         = active && in_valid && !push;

    result_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state and status outputs.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = (wi_count == '0) ? DONE : ACTIVE;
            end
            ACTIVE: begin
                busy = 1'b1;
                if (pop && ((tx_cnt + CNT_ONE) == total_q)) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Job parameters, result counters and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q     <= '0;
            total_q    <= '0;
            rx_cnt     <= '0;
            tx_cnt     <= '0;
            overflow_q <= 1'b0;
        end else if (accept_start) begin
            base_q     <= base_addr;
            total_q    <= TOT_W'(wi_count) * TOT_W'(RESULTS_PER_WI);
            rx_cnt     <= '0;
            tx_cnt     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) rx_cnt     <= rx_cnt + CNT_ONE;
            if (pop)  tx_cnt     <= tx_cnt + CNT_ONE;
            if (drop) overflow_q <= 1'b1;
        end
    end

    // Address wraps modulo 2^ADDR_W; data is zero whenever no request is up.
    assign mem.mem_req_valid = req_valid;
    assign mem.mem_req_addr  = base_q + ADDR_W'(tx_cnt);
    assign mem.mem_req_data  = req_valid ? fifo_head : '0;
    assign overflow          = overflow_q;
    assign dbg_state         = state;

endmodule

// File: tb/tb_matrix_result_writer.sv
// Bench for matrix_result_writer: a job-level reference model (word counts,
// buffer occupancy and an expected write queue) checked every cycle, a table
// of directed jobs, hand-written corner sequences and randomized jobs.
module tb_matrix_result_writer;
    import matrix_proc_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int WI_W   = 8;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [WI_W-1:0]   wi_count;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              ready;
    logic              busy;
    logic              done;
    logic              overflow;
    writer_state_t     dbg_state;

    matrix_result_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();
    assign mem_if.mem_req_ready = ready;

    matrix_result_writer #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .WI_W       (WI_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .wi_count  (wi_count),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .mem       (mem_if),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "time limit");
    end

    // Scoreboard and reference model state.
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_writes = 0;
    int  n_done   = 0;
    int  m_phase  = 0;   // 0 idle, 1 job running, 2 done pulse
    int  m_base   = 0;
    int  m_total  = 0;
    int  m_rx     = 0;
    int  m_tx     = 0;
    bit  m_ovf    = 1'b0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    typedef struct {
        int   base;
        int   wc;
        int   n_words;
        int   rmode;      // 0 ready always, 1 ready low for 12 cycles, 2 random
        int   exp_writes;
        int   exp_done;
        logic exp_ovf;
    } job_vec_t;

    job_vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: compare outputs with the model, advance the model with
    // the inputs currently applied, then step past the next edge.
    task automatic tick();
        int occ;
        bit pop;
        bit acc;
        occ = m_rx - m_tx;
        check("busy", 64'(busy), 64'(m_phase == 1));
        check("done", 64'(done), 64'(m_phase == 2));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("req_valid", 64'(mem_if.mem_req_valid), 64'(m_phase == 1 && occ > 0));
        if (mem_if.mem_req_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL req_unexpected: addr 0x%0h data 0x%0h, expected no request",
                         mem_if.mem_req_addr, mem_if.mem_req_data);
            end else if ({mem_if.mem_req_addr, mem_if.mem_req_data} !== exp_q[0]) begin
                n_fail++;
                $display("FAIL req_addr_data: got 0x%0h, expected 0x%0h",
                         {mem_if.mem_req_addr, mem_if.mem_req_data}, exp_q[0]);
            end
        end
        if (rst_n && mem_if.mem_req_valid === 1'b1 && ready) n_writes++;
        if (done === 1'b1) n_done++;

        pop = (m_phase == 1) && (occ > 0) && (ready == 1'b1);
        if (!rst_n) begin
            m_phase = 0; m_base = 0; m_total = 0; m_rx = 0; m_tx = 0; m_ovf = 1'b0;
            exp_q.delete();
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_base  = int'(base_addr);
                    m_total = int'(wi_count) * 4;
                    m_rx    = 0;
                    m_tx    = 0;
                    m_ovf   = 1'b0;
                    m_phase = (m_total == 0) ? 2 : 1;
                end
                1: begin
                    acc = in_valid && (m_rx < m_total) && (occ < DEPTH || pop);
                    if (pop) begin
                        void'(exp_q.pop_front());
                        m_tx++;
                    end
                    if (acc) begin
                        exp_q.push_back({16'((m_base + m_rx) % 65536), in_data});
                        m_rx++;
                    end
                    if (in_valid && !acc) m_ovf = 1'b1;
                    if (pop && m_tx == m_total) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    // Launch a job and feed it until done is seen with all words offered,
    // or the cycle budget runs out.
    task automatic run_job(input int base, input int wc, input int n_words,
                           input int rmode, input int budget);
        int sent;
        int d0;
        sent      = 0;
        d0        = n_done;
        base_addr = ADDR_W'(base);
        wi_count  = WI_W'(wc);
        start     = 1'b1;
        in_valid  = 1'b0;
        ready     = (rmode == 0);
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            case (rmode)
                0:       ready = 1'b1;
                1:       ready = (cyc >= 12);
                default: ready = ($urandom_range(0, 3) != 0);
            endcase
            in_valid = (sent < n_words) && (rmode != 2 || $urandom_range(0, 2) != 0);
            in_data  = (rmode == 2) ? DATA_W'($urandom) : DATA_W'(32'hA0 + sent);
            if (in_valid) sent++;
            tick();
            if (n_done > d0 && sent >= n_words) break;
        end
        in_valid = 1'b0;
        ready    = 1'b0;
        tick();
    endtask

    task automatic pulse_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        ready    = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int w0;
        int d0;
        int wc;

        vecs[0] = '{base: 32'h0100, wc: 1, n_words: 4, rmode: 0, exp_writes: 4, exp_done: 1, exp_ovf: 1'b0};
        vecs[1] = '{base: 32'h0100, wc: 2, n_words: 8, rmode: 1, exp_writes: 8, exp_done: 1, exp_ovf: 1'b0};
        vecs[2] = '{base: 32'hFFFE, wc: 1, n_words: 4, rmode: 0, exp_writes: 4, exp_done: 1, exp_ovf: 1'b0};
        vecs[3] = '{base: 32'h0040, wc: 0, n_words: 0, rmode: 0, exp_writes: 0, exp_done: 1, exp_ovf: 1'b0};
        vecs[4] = '{base: 32'h0200, wc: 1, n_words: 6, rmode: 0, exp_writes: 4, exp_done: 1, exp_ovf: 1'b1};

        // Reset.
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        ready     = 1'b0;
        base_addr = '0;
        wi_count  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_valid", 64'(mem_if.mem_req_valid), 64'(0));
        check("reset_addr", 64'(mem_if.mem_req_addr), 64'(0));
        check("reset_data", 64'(mem_if.mem_req_data), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_overflow", 64'(overflow), 64'(0));

        // Directed job table.
        for (int i = 0; i < 5; i++) begin
            w0 = n_writes;
            d0 = n_done;
            run_job(vecs[i].base, vecs[i].wc, vecs[i].n_words, vecs[i].rmode, 60);
            check($sformatf("vec%0d_writes", i), 64'(n_writes - w0), 64'(vecs[i].exp_writes));
            check($sformatf("vec%0d_done", i), 64'(n_done - d0), 64'(vecs[i].exp_done));
            check($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_drained", i), 64'(exp_q.size()), 64'(0));
        end

        // Overflow: ninth word into a full buffer is dropped, flag is sticky.
        w0 = n_writes;
        d0 = n_done;
        base_addr = 16'h0500; wi_count = 8'd3; start = 1'b1; ready = 1'b0; in_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(32'hB0 + i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("ovf_set", 64'(overflow), 64'(1));
        ready = 1'b1;
        repeat (10) tick();
        check("ovf_writes", 64'(n_writes - w0), 64'(8));
        check("ovf_no_done", 64'(n_done - d0), 64'(0));
        check("ovf_busy", 64'(busy), 64'(1));
        check("ovf_sticky", 64'(overflow), 64'(1));
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(32'hC0 + i);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10 && n_done == d0; i++) tick();
        check("ovf_done", 64'(n_done - d0), 64'(1));
        tick();
        check("ovf_held_idle", 64'(overflow), 64'(1));
        base_addr = 16'h0000; wi_count = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("ovf_cleared", 64'(overflow), 64'(0));
        tick();

        // Full buffer with a simultaneous pop and push: no drop.
        w0 = n_writes;
        d0 = n_done;
        base_addr = 16'h0600; wi_count = 8'd3; start = 1'b1; ready = 1'b0; in_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(32'hD0 + i);
            tick();
        end
        in_valid = 1'b1; in_data = 32'hD8; ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("full_pop_no_ovf", 64'(overflow), 64'(0));
        repeat (8) tick();
        check("full_pop_writes", 64'(n_writes - w0), 64'(9));
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(32'hD9 + i);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10 && n_done == d0; i++) tick();
        check("full_pop_total", 64'(n_writes - w0), 64'(12));
        check("full_pop_done", 64'(n_done - d0), 64'(1));
        check("full_pop_ovf_end", 64'(overflow), 64'(0));
        ready = 1'b0;
        tick();

        // Reset after two of four writes, then a clean job from a new base.
        w0 = n_writes;
        base_addr = 16'h0300; wi_count = 8'd1; start = 1'b1; ready = 1'b1; in_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4 && (n_writes - w0) < 2; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(32'hE0 + i);
            tick();
        end
        check("rst_mid_writes", 64'(n_writes - w0), 64'(2));
        pulse_reset();
        check("rst_mid_valid", 64'(mem_if.mem_req_valid), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
        w0 = n_writes;
        ready = 1'b1;
        tick();
        check("rst_mid_quiet", 64'(n_writes - w0), 64'(0));
        w0 = n_writes;
        d0 = n_done;
        run_job(32'h0400, 1, 4, 0, 20);
        check("rst_next_writes", 64'(n_writes - w0), 64'(4));
        check("rst_next_done", 64'(n_done - d0), 64'(1));

        // Randomized jobs against the model.
        for (int j = 0; j < 8; j++) begin
            wc = $urandom_range(0, 5);
            run_job($urandom_range(0, 65535), wc, wc * 4 + $urandom_range(0, 3), 2, 250);
            if (m_phase != 0) pulse_reset();
            else check("rand_drained", 64'(exp_q.size()), 64'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
